// File: rtl/debug_unit_v2.sv
// debug_unit_v2 -- host debug controller between a UART byte link and the CPU.
//
// Decodes byte commands from the host and answers byte-serially:
//   0x01 c      dump debug channel c (CH_BYTES bytes, LSB first), then 0xA5
//   0x02 a      read data-memory word a (WORD_WIDTH/8 bytes, LSB first), then 0xA5
//   0x03 n ...  load n little-endian words into instruction memory from address 0, then 0xA5
//   0x04 / 0x05 enter RUN / HALT mode, then 0xA5
//   0x06 k      in HALT, enable the CPU for exactly k cycles, then 0xA5
//   other       0xEE
//
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_rx_data/i_rx_valid      received byte handshake (one-cycle valid pulse)
//   o_tx_data/o_tx_start      byte to send + one-cycle start; data held until i_tx_done
//   i_tx_done                 transmitter finished the current byte
//   i_dbg_ch                  NUM_CH packed channel slots of CH_BYTES bytes each
//   o_dmem_addr/i_dmem_data   debug read port of data memory (MEM_RD_LAT cycle latency)
//   o_imem_we/addr/data       instruction-memory write port
//   o_cpu_en                  CPU clock enable
//   o_loading                 program load in progress
//
// Optional feature: define DEBUG_UNIT_TIMEOUT_EN to abort a command with 0xEE when
// no byte arrives for TIMEOUT_CYCLES cycles while an argument or load byte is expected.
module debug_unit_v2 #(
    parameter int WORD_WIDTH      = 32,
    parameter int NUM_CH          = 5,
    parameter int CH_BYTES        = 128,
    parameter int IMEM_ADDR_WIDTH = 8,
    parameter int DMEM_ADDR_WIDTH = 8,
    parameter int MEM_RD_LAT      = 1,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic [7:0]                   i_rx_data,
    input  logic                         i_rx_valid,
    output logic [7:0]                   o_tx_data,
    output logic                         o_tx_start,
    input  logic                         i_tx_done,
    input  logic [NUM_CH*CH_BYTES*8-1:0] i_dbg_ch,
    output logic [DMEM_ADDR_WIDTH-1:0]   o_dmem_addr,
    input  logic [WORD_WIDTH-1:0]        i_dmem_data,
    output logic                         o_imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0]   o_imem_addr,
    output logic [WORD_WIDTH-1:0]        o_imem_data,
    output logic                         o_cpu_en,
    output logic                         o_loading
);
    localparam int CH_BITS    = CH_BYTES * 8;
    localparam int WORD_BYTES = WORD_WIDTH / 8;
    localparam int CH_IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BIDX_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    localparam logic [7:0] OP_DUMP = 8'h01;
    localparam logic [7:0] OP_READ = 8'h02;
    localparam logic [7:0] OP_LOAD = 8'h03;
    localparam logic [7:0] OP_RUN  = 8'h04;
    localparam logic [7:0] OP_HALT = 8'h05;
    localparam logic [7:0] OP_STEP = 8'h06;
    localparam logic [7:0] REPLY_ACK = 8'hA5;
    localparam logic [7:0] REPLY_ERR = 8'hEE;

    typedef enum logic [3:0] {
        ST_IDLE, ST_GET_ARG, ST_MEM_WAIT, ST_SEND, ST_WAIT_TX,
        ST_LOAD_BYTE, ST_LOAD_WRITE, ST_STEP, ST_ACK, ST_ERR, ST_REPLY_WAIT
    } state_t;

    state_t                       state_reg, state_next;
    logic                         run_reg, run_next;
    logic                         loading_reg, loading_next;
    logic [7:0]                   opcode_reg, opcode_next;
    logic [15:0]                  cnt_reg, cnt_next;       // bytes / words / cycles remaining
    logic [BIDX_W-1:0]            byte_idx_reg, byte_idx_next;
    logic [CH_BITS-1:0]           shift_reg, shift_next;
    logic [WORD_WIDTH-1:0]        word_reg, word_next;
    logic [IMEM_ADDR_WIDTH-1:0]   imem_addr_reg, imem_addr_next;
    logic [DMEM_ADDR_WIDTH-1:0]   dmem_addr_reg, dmem_addr_next;
    logic [7:0]                   reply_reg, reply_next;

    // A byte colliding with i_tx_done is dropped; the tx event wins.
    logic rx_ok;
    assign rx_ok = i_rx_valid & ~i_tx_done;

    logic timeout_hit;

    // Split the packed channel bus into addressable slots.
    logic [CH_BITS-1:0] ch_slot [NUM_CH];
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_slot[gi] = i_dbg_ch[gi*CH_BITS +: CH_BITS];
        end
    endgenerate

`ifdef DEBUG_UNIT_TIMEOUT_EN
    logic [31:0] to_cnt_reg;
    logic        waiting;
    assign waiting     = (state_reg == ST_GET_ARG) || (state_reg == ST_LOAD_BYTE);
    assign timeout_hit = waiting && !rx_ok && (to_cnt_reg == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            to_cnt_reg <= '0;
        end else if (!waiting || rx_ok) begin
            to_cnt_reg <= '0;
        end else begin
            to_cnt_reg <= to_cnt_reg + 32'd1;
        end
    end
`else
    // Keeps the parameter referenced when the timeout is compiled out.
    localparam int timeout_unused = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg     <= ST_IDLE;
            run_reg       <= 1'b0;
            loading_reg   <= 1'b0;
            opcode_reg    <= '0;
            cnt_reg       <= '0;
            byte_idx_reg  <= '0;
            shift_reg     <= '0;
            word_reg      <= '0;
            imem_addr_reg <= '0;
            dmem_addr_reg <= '0;
            reply_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            run_reg       <= run_next;
            loading_reg   <= loading_next;
            opcode_reg    <= opcode_next;
            cnt_reg       <= cnt_next;
            byte_idx_reg  <= byte_idx_next;
            shift_reg     <= shift_next;
            word_reg      <= word_next;
            imem_addr_reg <= imem_addr_next;
            dmem_addr_reg <= dmem_addr_next;
            reply_reg     <= reply_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        run_next       = run_reg;
        loading_next   = loading_reg;
        opcode_next    = opcode_reg;
        cnt_next       = cnt_reg;
        byte_idx_next  = byte_idx_reg;
        shift_next     = shift_reg;
        word_next      = word_reg;
        imem_addr_next = imem_addr_reg;
        dmem_addr_next = dmem_addr_reg;
        reply_next     = reply_reg;

        case (state_reg)
            ST_IDLE: if (rx_ok) begin
                opcode_next = i_rx_data;
                case (i_rx_data)
                    OP_RUN:  begin run_next = 1'b1; state_next = ST_ACK; end
                    OP_HALT: begin run_next = 1'b0; state_next = ST_ACK; end
                    OP_DUMP, OP_READ, OP_LOAD, OP_STEP: state_next = ST_GET_ARG;
                    default: state_next = ST_ERR;
                endcase
            end
            ST_GET_ARG: begin
                if (timeout_hit) begin
                    state_next = ST_ERR;
                end else if (rx_ok) begin
                    case (opcode_reg)
                        OP_DUMP: begin
                            if (int'(i_rx_data) < NUM_CH) begin
                                shift_next = ch_slot[i_rx_data[CH_IDX_W-1:0]];
                                cnt_next   = 16'(CH_BYTES);
                                state_next = ST_SEND;
                            end else begin
                                state_next = ST_ERR;
                            end
                        end
                        OP_READ: begin
                            dmem_addr_next = i_rx_data[DMEM_ADDR_WIDTH-1:0];
                            cnt_next       = 16'(MEM_RD_LAT);
                            state_next     = ST_MEM_WAIT;
                        end
                        OP_LOAD: begin
                            if (i_rx_data == 8'd0) begin
                                state_next = ST_ACK;
                            end else begin
                                loading_next   = 1'b1;
                                cnt_next       = 16'(i_rx_data);
                                imem_addr_next = '0;
                                byte_idx_next  = '0;
                                state_next     = ST_LOAD_BYTE;
                            end
                        end
                        default: begin  // step
                            if (run_reg || i_rx_data == 8'd0) begin
                                state_next = ST_ACK;
                            end else begin
                                cnt_next   = 16'(i_rx_data);
                                state_next = ST_STEP;
                            end
                        end
                    endcase
                end
            end
            // The address register is valid from the first wait cycle; data is
            // captured at the end of the MEM_RD_LAT-th wait cycle.
            ST_MEM_WAIT: begin
                if (cnt_reg == 16'd1) begin
                    shift_next = CH_BITS'(i_dmem_data);
                    cnt_next   = 16'(WORD_BYTES);
                    state_next = ST_SEND;
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            ST_SEND: state_next = ST_WAIT_TX;
            ST_WAIT_TX: if (i_tx_done) begin
                if (cnt_reg == 16'd1) begin
                    state_next = ST_ACK;
                end else begin
                    shift_next = shift_reg >> 8;
                    cnt_next   = cnt_reg - 16'd1;
                    state_next = ST_SEND;
                end
            end
            ST_LOAD_BYTE: begin
                if (timeout_hit) begin
                    loading_next = 1'b0;
                    state_next   = ST_ERR;
                end else if (rx_ok) begin
                    word_next = WORD_WIDTH'({i_rx_data, word_reg} >> 8);
                    if (byte_idx_reg == BIDX_W'(WORD_BYTES - 1)) begin
                        byte_idx_next = '0;
                        state_next    = ST_LOAD_WRITE;
                    end else begin
                        byte_idx_next = byte_idx_reg + BIDX_W'(1);
                    end
                end
            end
            ST_LOAD_WRITE: begin
                imem_addr_next = imem_addr_reg + IMEM_ADDR_WIDTH'(1);
                cnt_next       = cnt_reg - 16'd1;
                if (cnt_reg == 16'd1) begin
                    loading_next = 1'b0;
                    state_next   = ST_ACK;
                end else begin
                    state_next = ST_LOAD_BYTE;
                end
            end
            ST_STEP: begin
                cnt_next = cnt_reg - 16'd1;
                if (cnt_reg == 16'd1) begin
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                reply_next = REPLY_ACK;
                state_next = ST_REPLY_WAIT;
            end
            ST_ERR: begin
                reply_next = REPLY_ERR;
                state_next = ST_REPLY_WAIT;
            end
            ST_REPLY_WAIT: if (i_tx_done) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_tx_data = 8'h00;
        case (state_reg)
            ST_SEND, ST_WAIT_TX: o_tx_data = shift_reg[7:0];
            ST_ACK:              o_tx_data = REPLY_ACK;
            ST_ERR:              o_tx_data = REPLY_ERR;
            ST_REPLY_WAIT:       o_tx_data = reply_reg;
            default:             o_tx_data = 8'h00;
        endcase
    end

    assign o_tx_start  = (state_reg == ST_SEND) || (state_reg == ST_ACK) || (state_reg == ST_ERR);
    assign o_imem_we   = (state_reg == ST_LOAD_WRITE);
    assign o_imem_addr = imem_addr_reg;
    assign o_imem_data = word_reg;
    assign o_dmem_addr = dmem_addr_reg;
    assign o_loading   = loading_reg;
    assign o_cpu_en    = (run_reg & ~loading_reg) | (state_reg == ST_STEP);

endmodule

// File: tb/tb_debug_unit_v2.sv
// Directed bench for debug_unit_v2 with a scoreboard: expected tx bytes and
// instruction-memory writes are queued as commands are issued, and independent
// monitor processes pop and compare whenever the DUT presents them.
module tb_debug_unit_v2;
    localparam int WORD_WIDTH     = 32;
    localparam int NUM_CH         = 5;
    localparam int CH_BYTES       = 16;
    localparam int IMEM_AW        = 8;
    localparam int DMEM_AW        = 8;
    localparam int MEM_RD_LAT     = 2;
    localparam int TIMEOUT_CYCLES = 50;

    logic                          i_clk = 1'b0;
    logic                          i_reset_n = 1'b0;
    logic [7:0]                    i_rx_data = 8'h00;
    logic                          i_rx_valid = 1'b0;
    logic [7:0]                    o_tx_data;
    logic                          o_tx_start;
    logic                          i_tx_done = 1'b0;
    logic [NUM_CH*CH_BYTES*8-1:0]  i_dbg_ch;
    logic [DMEM_AW-1:0]            o_dmem_addr;
    logic [WORD_WIDTH-1:0]         i_dmem_data;
    logic                          o_imem_we;
    logic [IMEM_AW-1:0]            o_imem_addr;
    logic [WORD_WIDTH-1:0]         o_imem_data;
    logic                          o_cpu_en;
    logic                          o_loading;

    debug_unit_v2 #(
        .WORD_WIDTH(WORD_WIDTH), .NUM_CH(NUM_CH), .CH_BYTES(CH_BYTES),
        .IMEM_ADDR_WIDTH(IMEM_AW), .DMEM_ADDR_WIDTH(DMEM_AW),
        .MEM_RD_LAT(MEM_RD_LAT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
        .i_dbg_ch(i_dbg_ch),
        .o_dmem_addr(o_dmem_addr), .i_dmem_data(i_dmem_data),
        .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data),
        .o_cpu_en(o_cpu_en), .o_loading(o_loading)
    );

    always #5 i_clk = ~i_clk;

    // Data memory model: one known word at 0x10, something else elsewhere.
    assign i_dmem_data = (o_dmem_addr == 8'h10) ? 32'hCAFEF00D : 32'h0BADBEEF;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rx_cyc = 0;
    int cen_cnt = 0;
    int cen_first = -1;
    bit tx_busy = 1'b0;
    logic [7:0]                  exp_tx[$];
    logic [IMEM_AW+WORD_WIDTH-1:0] exp_wr[$];
    int                          start_cyc_q[$];

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Tx scoreboard monitor plus transmitter model (done 4 cycles after start).
    initial begin
        int tx_cnt;
        logic [7:0] cur;
        logic [7:0] e;
        tx_cnt = 0;
        cur = 8'h00;
        forever begin
            @(posedge i_clk);
            #1;
            i_tx_done = 1'b0;
            if (tx_cnt > 0) begin
                n_vec++;
                if (o_tx_data !== cur) begin
                    n_err++;
                    $display("FAIL tx_hold: got %02h, expected %02h", o_tx_data, cur);
                end
                tx_cnt--;
                if (tx_cnt == 0) begin
                    i_tx_done = 1'b1;
                    tx_busy = 1'b0;
                end
            end
            if (o_tx_start) begin
                start_cyc_q.push_back(cyc);
                n_vec++;
                if (exp_tx.size() == 0) begin
                    n_err++;
                    $display("FAIL tx_unexpected: got %02h, expected none", o_tx_data);
                end else begin
                    e = exp_tx.pop_front();
                    $display("tx byte %02h (expected %02h) cycle %0d", o_tx_data, e, cyc);
                    if (o_tx_data !== e) begin
                        n_err++;
                        $display("FAIL tx_byte: got %02h, expected %02h", o_tx_data, e);
                    end
                end
                cur = o_tx_data;
                tx_busy = 1'b1;
                tx_cnt = 3;
            end
        end
    end

    // Instruction-memory write monitor.
    initial begin
        logic [IMEM_AW+WORD_WIDTH-1:0] w;
        forever begin
            @(posedge i_clk);
            #1;
            if (o_imem_we) begin
                n_vec++;
                if (exp_wr.size() == 0) begin
                    n_err++;
                    $display("FAIL imem_unexpected: got addr %0h data %08h", o_imem_addr, o_imem_data);
                end else begin
                    w = exp_wr.pop_front();
                    $display("imem write addr %0h data %08h", o_imem_addr, o_imem_data);
                    if ({o_imem_addr, o_imem_data} !== w) begin
                        n_err++;
                        $display("FAIL imem_write: got %0h/%08h, expected %0h/%08h",
                                 o_imem_addr, o_imem_data, w[WORD_WIDTH +: IMEM_AW], w[WORD_WIDTH-1:0]);
                    end
                end
            end
        end
    end

    // CPU enable watcher: counts enabled cycles and checks the load gate.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (o_cpu_en) begin
                cen_cnt++;
                if (cen_first < 0) cen_first = cyc;
            end
            if (o_loading) begin
                n_vec++;
                if (o_cpu_en !== 1'b0) begin
                    n_err++;
                    $display("FAIL cpu_en_during_load: got %0b, expected 0", o_cpu_en);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge i_clk);
        #1;
        i_rx_data = b;
        i_rx_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_rx_valid = 1'b0;
        rx_cyc = cyc;
    endtask

    task automatic clear_obs();
        start_cyc_q.delete();
        cen_cnt = 0;
        cen_first = -1;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while ((exp_tx.size() != 0 || tx_busy) && t < 4000) begin
            @(posedge i_clk);
            t++;
        end
        chk({name, "_timeout"}, 64'(t >= 4000), 64'd0);
        repeat (3) @(posedge i_clk);
        #1;
    endtask

    function automatic int first_start();
        if (start_cyc_q.size() == 0) return -1;
        return start_cyc_q[0];
    endfunction

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_tx_start"}, 64'(o_tx_start), 64'd0);
        chk({tag, "_tx_data"}, 64'(o_tx_data), 64'd0);
        chk({tag, "_imem_we"}, 64'(o_imem_we), 64'd0);
        chk({tag, "_imem_addr"}, 64'(o_imem_addr), 64'd0);
        chk({tag, "_imem_data"}, 64'(o_imem_data), 64'd0);
        chk({tag, "_dmem_addr"}, 64'(o_dmem_addr), 64'd0);
        chk({tag, "_cpu_en"}, 64'(o_cpu_en), 64'd0);
        chk({tag, "_loading"}, 64'(o_loading), 64'd0);
    endtask

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < CH_BYTES; i++) begin
                i_dbg_ch[(c*CH_BYTES+i)*8 +: 8] = (c == 2) ? 8'(i + 1) : 8'(8'h80 + c*16 + i);
            end
        end

        // Reset state.
        repeat (3) @(posedge i_clk);
        #1;
        chk_outputs_zero("reset");
        i_reset_n = 1'b1;
        repeat (2) @(posedge i_clk);

        // HALT then step 3.
        exp_tx.push_back(8'hA5);
        send_byte(8'h05);
        wait_done("halt");
        clear_obs();
        exp_tx.push_back(8'hA5);
        send_byte(8'h06);
        send_byte(8'h03);
        wait_done("step3");
        chk("step3_cycles", 64'(cen_cnt), 64'd3);
        chk("step3_first_en", 64'(cen_first), 64'(rx_cyc));
        chk("step3_ack_time", 64'(first_start()), 64'(rx_cyc + 3));

        // Step 0: ACK without enabling the CPU.
        clear_obs();
        exp_tx.push_back(8'hA5);
        send_byte(8'h06);
        send_byte(8'h00);
        wait_done("step0");
        chk("step0_cycles", 64'(cen_cnt), 64'd0);

        // Dump channel 2; input changes right after the snapshot.
        clear_obs();
        for (int i = 0; i < CH_BYTES; i++) exp_tx.push_back(8'(i + 1));
        exp_tx.push_back(8'hA5);
        send_byte(8'h01);
        send_byte(8'h02);
        i_dbg_ch[2*CH_BYTES*8 +: CH_BYTES*8] = '1;
        wait_done("dump2");
        chk("dump2_first_start", 64'(first_start()), 64'(rx_cyc));

        // Bad channel and unknown opcode.
        exp_tx.push_back(8'hEE);
        send_byte(8'h01);
        send_byte(8'(NUM_CH));
        wait_done("dump_bad");
        exp_tx.push_back(8'hEE);
        send_byte(8'h7F);
        wait_done("bad_op");

        // Data-memory read at 0x10.
        clear_obs();
        exp_tx.push_back(8'h0D);
        exp_tx.push_back(8'hF0);
        exp_tx.push_back(8'hFE);
        exp_tx.push_back(8'hCA);
        exp_tx.push_back(8'hA5);
        send_byte(8'h02);
        send_byte(8'h10);
        wait_done("read");
        chk("read_first_start", 64'(first_start()), 64'(rx_cyc + MEM_RD_LAT));
        chk("read_dmem_addr", 64'(o_dmem_addr), 64'h10);

        // RUN mode, then a two-word program load with the CPU gated off.
        exp_tx.push_back(8'hA5);
        send_byte(8'h04);
        wait_done("run");
        chk("run_cpu_en", 64'(o_cpu_en), 64'd1);
        exp_wr.push_back({8'h00, 32'h12345678});
        exp_wr.push_back({8'h01, 32'hDEADBEEF});
        exp_tx.push_back(8'hA5);
        send_byte(8'h03);
        send_byte(8'h02);
        chk("load_loading_high", 64'(o_loading), 64'd1);
        chk("load_cpu_en_low", 64'(o_cpu_en), 64'd0);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        send_byte(8'hDE);
        wait_done("load");
        chk("load_loading_low", 64'(o_loading), 64'd0);
        chk("load_writes_left", 64'(exp_wr.size()), 64'd0);
        chk("load_cpu_en_back", 64'(o_cpu_en), 64'd1);
        exp_tx.push_back(8'hA5);
        send_byte(8'h05);
        wait_done("halt2");
        chk("halt2_cpu_en", 64'(o_cpu_en), 64'd0);

        // Reset in the middle of a load.
        send_byte(8'h03);
        send_byte(8'h02);
        send_byte(8'h78);
        send_byte(8'h56);
        chk("midload_loading", 64'(o_loading), 64'd1);
        i_reset_n = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        repeat (2) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        exp_tx.push_back(8'hA5);
        send_byte(8'h04);
        wait_done("run_after_reset");
        chk("run_after_reset_cpu_en", 64'(o_cpu_en), 64'd1);
        exp_tx.push_back(8'hA5);
        send_byte(8'h05);
        wait_done("halt3");

`ifdef DEBUG_UNIT_TIMEOUT_EN
        // Silence during a load aborts with ERR.
        exp_tx.push_back(8'hEE);
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(8'h11);
        chk("timeout_loading_high", 64'(o_loading), 64'd1);
        wait_done("timeout");
        chk("timeout_loading_low", 64'(o_loading), 64'd0);
`endif

        chk("tx_queue_empty", 64'(exp_tx.size()), 64'd0);
        chk("imem_queue_empty", 64'(exp_wr.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
